// File: rtl/sdram_read_if.sv
// Read-engine side of the SDRAM controller: trigger/arbiter handshake, command pins and data return.
interface sdram_read_if;
  logic        rd_trig;
  logic        rd_en;
  logic        rd_req;
  logic        flag_rd_end;
  logic        ref_req;
  logic [3:0]  rd_cmd;
  logic [11:0] rd_addr;
  logic [1:0]  bank_addr;
  logic [15:0] sdram_dq;
  logic [15:0] rd_data;
  logic        rd_data_vld;
  logic        rd_busy;

  modport master (
    output rd_trig, rd_en, ref_req, sdram_dq,
    input  rd_req, flag_rd_end, rd_cmd, rd_addr, bank_addr, rd_data, rd_data_vld, rd_busy
  );

  modport slave (
    input  rd_trig, rd_en, ref_req, sdram_dq,
    output rd_req, flag_rd_end, rd_cmd, rd_addr, bank_addr, rd_data, rd_data_vld, rd_busy
  );
endinterface

// File: rtl/sdram_read.sv
// SDRAM read engine: requests the bus, walks ROW_NUM rows with ACTIVE/READ/PRECHARGE
// and captures burst data; yields the bus at burst boundaries for refresh.
module sdram_read #(
  parameter int unsigned CAS_LAT   = 3,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned TRCD      = 2,
  parameter int unsigned TRP       = 2,
  parameter int unsigned ROW_NUM   = 2
) (
  input  logic        i_sclk,
  input  logic        i_s_rst,
  sdram_read_if.slave bus
);

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned ROW_W    = 12;
  localparam int unsigned COL_W    = 8;
  localparam int unsigned BEAT_W   = 4;
  localparam int unsigned PRE_WAIT = (TRP > CAS_LAT + 1) ? TRP : CAS_LAT + 1;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [ROW_W-1:0] ADDR_A10 = 12'h400;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACT, S_RD, S_PRE} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
  logic [ROW_W-1:0]  r_row,   w_row_nxt;
  logic [COL_W-1:0]  r_col,   w_col_nxt;
  logic              r_busy,  w_busy_nxt;
  logic              r_rd_req, w_rd_req_nxt;
  logic              r_flag,  w_flag_nxt;
  logic [3:0]        r_cmd,   w_cmd_nxt;
  logic [ROW_W-1:0]  r_addr,  w_addr_nxt;
  logic [1:0]        r_bank;
  logic [COL_W-1:0]  w_col_inc;

  logic [CAS_LAT-1:0] r_rd_sr;
  logic [BEAT_W-1:0]  r_beats;
  logic               r_vld;
  logic [15:0]        r_data;
  logic               w_is_read;

  assign w_col_inc = r_col + COL_W'(BURST_LEN);
  assign w_is_read = (r_cmd == CMD_RD);

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_row_nxt    = r_row;
    w_col_nxt    = r_col;
    w_busy_nxt   = r_busy;
    w_rd_req_nxt = 1'b0;
    w_flag_nxt   = 1'b0;
    w_cmd_nxt    = CMD_NOP;
    w_addr_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.rd_trig) begin
          w_state_nxt  = S_REQ;
          w_busy_nxt   = 1'b1;
          w_row_nxt    = '0;
          w_col_nxt    = '0;
          w_rd_req_nxt = 1'b1;
        end
      end
      S_REQ: begin
        if (bus.rd_en) begin
          w_state_nxt = S_ACT;
          w_cmd_nxt   = CMD_ACT;
          w_addr_nxt  = r_row;
          w_cnt_nxt   = '0;
        end else begin
          w_rd_req_nxt = 1'b1;
        end
      end
      S_ACT: begin
        if (r_cnt == CNT_W'(TRCD)) begin
          w_state_nxt = S_RD;
          w_cmd_nxt   = CMD_RD;
          w_addr_nxt  = ROW_W'(r_col);
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RD: begin
        if (r_cnt == CNT_W'(BURST_LEN - 1)) begin
          // A wrapped column always advances the row, even when refresh also interrupts
          w_col_nxt = w_col_inc;
          if (w_col_inc == '0) w_row_nxt = r_row + ROW_W'(1);
          w_cnt_nxt = '0;
          if (bus.ref_req || (w_col_inc == '0)) begin
            w_state_nxt = S_PRE;
            w_cmd_nxt   = CMD_PRE;
            w_addr_nxt  = ADDR_A10;
          end else begin
            w_cmd_nxt  = CMD_RD;
            w_addr_nxt = ROW_W'(w_col_inc);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_PRE: begin
        if (r_cnt == CNT_W'(PRE_WAIT)) begin
          if (r_row == ROW_W'(ROW_NUM)) begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
          end else begin
            w_state_nxt  = S_REQ;
            w_rd_req_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(PRE_WAIT - 1)) w_flag_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and command registers
  always_ff @(posedge i_sclk or posedge i_s_rst) begin
    if (i_s_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_busy   <= 1'b0;
      r_rd_req <= 1'b0;
      r_flag   <= 1'b0;
      r_cmd    <= CMD_NOP;
      r_addr   <= '0;
      r_bank   <= 2'b00;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_row    <= w_row_nxt;
      r_col    <= w_col_nxt;
      r_busy   <= w_busy_nxt;
      r_rd_req <= w_rd_req_nxt;
      r_flag   <= w_flag_nxt;
      r_cmd    <= w_cmd_nxt;
      r_addr   <= w_addr_nxt;
      r_bank   <= 2'b00;
    end
  end

  // Capture pipe tracks issued READs independently of state so the last burst drains during PRE
  always_ff @(posedge i_sclk or posedge i_s_rst) begin
    if (i_s_rst) begin
      r_rd_sr <= '0;
      r_beats <= '0;
      r_vld   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_rd_sr <= CAS_LAT'({r_rd_sr, w_is_read});
      r_data  <= bus.sdram_dq;
      if (r_rd_sr[CAS_LAT-1]) begin
        r_beats <= BEAT_W'(BURST_LEN - 1);
        r_vld   <= 1'b1;
      end else if (r_beats != '0) begin
        r_beats <= r_beats - BEAT_W'(1);
        r_vld   <= 1'b1;
      end else begin
        r_vld <= 1'b0;
      end
    end
  end

  assign bus.rd_req      = r_rd_req;
  assign bus.flag_rd_end = r_flag;
  assign bus.rd_cmd      = r_cmd;
  assign bus.rd_addr     = r_addr;
  assign bus.bank_addr   = r_bank;
  assign bus.rd_data     = r_data;
  assign bus.rd_data_vld = r_vld;
  assign bus.rd_busy     = r_busy;

endmodule

// File: tb/tb_sdram_read.sv
// Directed bench for sdram_read: arbiter/refresh stimulus, SDRAM data model returning the column index.
module tb_sdram_read;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_read_if bus();

  sdram_read u_dut (
    .i_sclk  (clk),
    .i_s_rst (rst),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Monitor state, written only by the monitor process
  bit         mon_clr = 1'b0;
  int         cyc = 0;
  int         vld_cnt, rd_cnt, act_cnt, pre_cnt, flag_cnt;
  int         data_err, col_err, act_err, pre_err, flag_err;
  int         first_act, first_rd, first_vld;
  logic [7:0] exp_col;
  bit         h_v [0:6];
  logic [7:0] h_c [0:6];

  // SDRAM data model plus command/data monitor, sampled 1 unit after the rising edge
  always @(posedge clk) begin
    #1;
    cyc++;
    for (int k = 6; k > 0; k--) begin
      h_v[k] = h_v[k-1];
      h_c[k] = h_c[k-1];
    end
    h_v[0] = (bus.rd_cmd == CMD_RD);
    h_c[0] = bus.rd_addr[7:0];
    if      (h_v[3]) bus.sdram_dq = 16'(h_c[3]);
    else if (h_v[4]) bus.sdram_dq = 16'(h_c[4]) + 16'd1;
    else if (h_v[5]) bus.sdram_dq = 16'(h_c[5]) + 16'd2;
    else if (h_v[6]) bus.sdram_dq = 16'(h_c[6]) + 16'd3;
    else             bus.sdram_dq = 16'hDEAD;

    if (rst || mon_clr) begin
      vld_cnt = 0; rd_cnt = 0; act_cnt = 0; pre_cnt = 0; flag_cnt = 0;
      data_err = 0; col_err = 0; act_err = 0; pre_err = 0; flag_err = 0;
      first_act = -1; first_rd = -1; first_vld = -1;
      exp_col = 8'd0;
    end else begin
      if (bus.rd_cmd == CMD_ACT) begin
        if (first_act < 0) first_act = cyc;
        if (bus.rd_addr != 12'(rd_cnt / 64)) act_err++;
        act_cnt++;
      end
      if (bus.rd_cmd == CMD_RD) begin
        if (first_rd < 0) first_rd = cyc;
        if (bus.rd_addr != {4'b0, exp_col}) col_err++;
        exp_col = exp_col + 8'd4;
        rd_cnt++;
      end
      if (bus.rd_cmd == CMD_PRE) begin
        if (bus.rd_addr != 12'h400) pre_err++;
        pre_cnt++;
      end
      if (bus.rd_data_vld) begin
        if (first_vld < 0) first_vld = cyc;
        if (bus.rd_data != 16'(vld_cnt % 256)) data_err++;
        vld_cnt++;
      end
      if (bus.flag_rd_end) begin
        if (vld_cnt != rd_cnt * 4) flag_err++;
        flag_cnt++;
      end
    end
  end

  // Start a job and play arbiter (grant 3 cycles after request) until done or a stop condition.
  // stop_on: 0 job end, 1 REQ, 2 ACT, 3 READ, 4 PRE.
  task automatic run_job(input int stop_on, input int ref_col, input bit poke,
                         output int act_after, output int rd_after);
    int wait_n;
    int phase;
    bit done;
    wait_n = -1; phase = 0; done = 1'b0;
    act_after = -1; rd_after = -1;
    bus.rd_trig = 1'b1;
    mon_clr = 1'b1;
    @(negedge clk);
    bus.rd_trig = 1'b0;
    mon_clr = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      bus.rd_en = 1'b0;
      if (poke) bus.rd_trig = (i == 40);
      case (stop_on)
        1:       done = bus.rd_req;
        2:       done = (bus.rd_cmd == CMD_ACT);
        3:       done = (bus.rd_cmd == CMD_RD);
        4:       done = (bus.rd_cmd == CMD_PRE);
        default: done = !bus.rd_busy;
      endcase
      if (!done) begin
        if (wait_n > 0) begin
          wait_n--;
          if (wait_n == 0) begin
            bus.rd_en = 1'b1;
            wait_n = -1;
          end
        end else if (bus.rd_req) begin
          wait_n = 3;
        end
        if (phase == 0 && ref_col >= 0 && bus.rd_cmd == CMD_RD && bus.rd_addr == 12'(ref_col)) begin
          bus.ref_req = 1'b1;
          phase = 1;
        end else if (phase == 1 && bus.rd_cmd == CMD_PRE) begin
          bus.ref_req = 1'b0;
          phase = 2;
        end else if (phase == 2 && act_after < 0 && bus.rd_cmd == CMD_ACT) begin
          act_after = int'(bus.rd_addr);
        end else if (phase == 2 && act_after >= 0 && rd_after < 0 && bus.rd_cmd == CMD_RD) begin
          rd_after = int'(bus.rd_addr);
        end
        @(negedge clk);
      end
    end
    check("job_done", 32'(done), 32'd1);
    bus.rd_trig = 1'b0;
    bus.rd_en   = 1'b0;
    bus.ref_req = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd"},  32'(bus.rd_cmd),      32'(CMD_NOP));
    check({tag, "_busy"}, 32'(bus.rd_busy),     32'd0);
    check({tag, "_req"},  32'(bus.rd_req),      32'd0);
    check({tag, "_vld"},  32'(bus.rd_data_vld), 32'd0);
    check({tag, "_flag"}, 32'(bus.flag_rd_end), 32'd0);
    check({tag, "_addr"}, 32'(bus.rd_addr),     32'd0);
  endtask

  initial begin
    int a, r;
    bus.rd_trig = 1'b0;
    bus.rd_en   = 1'b0;
    bus.ref_req = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_data", 32'(bus.rd_data),   32'd0);
    check("reset_bank", 32'(bus.bank_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Grant while idle must be ignored
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    repeat (4) @(negedge clk);
    check_idle_outputs("idle_en");
    check("idle_en_act", 32'(act_cnt), 32'd0);

    // Full job, with a stray rd_trig pulsed mid-job
    run_job(0, -1, 1'b1, a, r);
    check("job1_vld",     32'(vld_cnt),  32'd512);
    check("job1_reads",   32'(rd_cnt),   32'd128);
    check("job1_acts",    32'(act_cnt),  32'd2);
    check("job1_pre",     32'(pre_cnt),  32'd2);
    check("job1_flag",    32'(flag_cnt), 32'd2);
    check("job1_data",    32'(data_err), 32'd0);
    check("job1_col",     32'(col_err),  32'd0);
    check("job1_actrow",  32'(act_err),  32'd0);
    check("job1_prea10",  32'(pre_err),  32'd0);
    check("job1_flagord", 32'(flag_err), 32'd0);
    check("job1_trcd",    32'(first_rd - first_act),  32'd3);
    check("job1_cas",     32'(first_vld - first_rd),  32'd4);
    check("job1_busy",    32'(bus.rd_busy), 32'd0);

    // Back-to-back job, refresh raised during the col-40 burst
    run_job(0, 40, 1'b0, a, r);
    check("job2_vld",     32'(vld_cnt),  32'd512);
    check("job2_flag",    32'(flag_cnt), 32'd3);
    check("job2_pre",     32'(pre_cnt),  32'd3);
    check("job2_acts",    32'(act_cnt),  32'd3);
    check("job2_resrow",  32'(a),        32'd0);
    check("job2_rescol",  32'(r),        32'd44);
    check("job2_data",    32'(data_err), 32'd0);
    check("job2_col",     32'(col_err),  32'd0);
    check("job2_actrow",  32'(act_err),  32'd0);
    check("job2_flagord", 32'(flag_err), 32'd0);
    check("job2_trcd",    32'(first_rd - first_act), 32'd3);
    repeat (10) @(negedge clk);
    check("job2_quiet",   32'(vld_cnt),  32'd512);

    // Reset asserted in REQ, ACT, RD and PRE
    for (int s = 1; s <= 4; s++) begin
      run_job(s, -1, 1'b0, a, r);
      rst = 1'b1;
      #1;
      check_idle_outputs($sformatf("rst_s%0d", s));
      @(negedge clk);
      check($sformatf("rst_s%0d_data", s), 32'(bus.rd_data), 32'd0);
      rst = 1'b0;
      @(negedge clk);
    end

    // Clean job after mid-operation resets
    run_job(0, -1, 1'b0, a, r);
    check("job3_vld",  32'(vld_cnt),  32'd512);
    check("job3_data", 32'(data_err), 32'd0);
    check("job3_flag", 32'(flag_cnt), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

endmodule
